reg_status_table_ckpt: RTL and testbench

//   Parametrised register status table (RST) for the Tomasulo dispatch path with branch checkpointing.

---
 rtl/reg_status_table_ckpt_pkg.sv | 24 ++
 rtl/reg_status_table_ckpt_bank.sv | 62 ++++++
 rtl/reg_status_table_ckpt.sv | 112 +++++++++++
 tb/tb_reg_status_table_ckpt.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_status_table_ckpt_pkg.sv
// Shared definitions for the register status table: entry field helpers and the CDB tag matcher.
// Tags and CDB vectors are zero-padded to the *_MAX widths so one function serves every parameterisation.
package reg_status_table_ckpt_pkg;

   localparam int TAG_W_DEF   = 6;
   localparam int NUM_CDB_DEF = 2;
   localparam int TAG_MAX     = 16;
   localparam int CDB_MAX     = 8;

   typedef logic [TAG_MAX-1:0]              tag_pad_t;
   typedef logic [CDB_MAX-1:0]              cdb_vld_pad_t;
   typedef logic [CDB_MAX-1:0][TAG_MAX-1:0] cdb_tag_pad_t;

   // Unused CDB lanes carry valid=0, so padding never produces a false match.
   function automatic logic cdb_match(input cdb_vld_pad_t vld, input cdb_tag_pad_t tags,
                                      input tag_pad_t tag);
      logic m;
      m = 1'b0;
      for (int k = 0; k < CDB_MAX; k++)
         m = m | (vld[k] & (tags[k] == tag));
      return m;
   endfunction

endpackage

// File: rtl/reg_status_table_ckpt_bank.sv
// Checkpoint storage: NUM_CKPT copies of the status table, each continuously scrubbed by the CDBs.
// One save port (whole-table write) and one restore read port (returns the scrubbed copy).
module reg_status_table_ckpt_bank
   import reg_status_table_ckpt_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int NUM_CDB  = NUM_CDB_DEF,
   parameter int NUM_CKPT = 4,
   parameter int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CDB-1:0]               cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]         cdb_tag,
   input  logic                             save_en,
   input  logic [CKPT_W-1:0]                save_id,
   input  logic [NUM_REGS-1:0][TAG_W:0]     save_data,
   input  logic [CKPT_W-1:0]                restore_id,
   output logic [NUM_REGS-1:0][TAG_W:0]     restore_data
);

   logic [NUM_CKPT-1:0][NUM_REGS-1:0][TAG_W:0] slot, slot_clr;
   cdb_vld_pad_t cdb_vld_p;
   cdb_tag_pad_t cdb_tag_p;

   always_comb begin
      cdb_vld_p = '0;
      cdb_tag_p = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         cdb_vld_p[k]             = cdb_valid[k];
         cdb_tag_p[k][TAG_W-1:0]  = cdb_tag[k*TAG_W +: TAG_W];
      end
   end

   always_comb begin
      tag_pad_t t;
      slot_clr = slot;
      for (int s = 0; s < NUM_CKPT; s++) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            t = '0;
            t[TAG_W-1:0] = slot[s][i][TAG_W-1:0];
            if (slot[s][i][TAG_W] && cdb_match(cdb_vld_p, cdb_tag_p, t))
               slot_clr[s][i][TAG_W] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot <= '0;
      end else begin
         slot <= slot_clr;
         if (save_en)
            slot[save_id] <= save_data;
      end
   end

   // Restored state already reflects this cycle's broadcasts.
   assign restore_data = slot_clr[restore_id];

endmodule

// File: rtl/reg_status_table_ckpt.sv
// Register status table: per-register pending producer tag, CDB clear/bypass, regfile write enables,
// and single-cycle branch checkpoint save/restore through the checkpoint bank.
module reg_status_table_ckpt
   import reg_status_table_ckpt_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int NUM_CDB  = NUM_CDB_DEF,
   parameter int NUM_CKPT = 4,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dispatch_wen,
   input  logic [ADDR_W-1:0]        dispatch_addr,
   input  logic [TAG_W-1:0]         dispatch_tag,
   input  logic                     dispatch_valid,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   input  logic [ADDR_W-1:0]        dispatch_rsaddr,
   output logic [TAG_W-1:0]         dispatch_rstag,
   output logic                     dispatch_rsvalid,
   input  logic [ADDR_W-1:0]        dispatch_rtaddr,
   output logic [TAG_W-1:0]         dispatch_rttag,
   output logic                     dispatch_rtvalid,
   output logic [NUM_REGS-1:0]      regfile_wen_onehot,
   input  logic                     ckpt_save,
   input  logic [CKPT_W-1:0]        ckpt_save_id,
   input  logic                     ckpt_restore,
   input  logic [CKPT_W-1:0]        ckpt_restore_id
);

   logic [NUM_REGS-1:0][TAG_W:0] live, live_next, restore_data;
   logic [NUM_REGS-1:0]          hit;
   logic                         disp_kill, disp_we;
   logic [TAG_W:0]               rs_ent, rt_ent;
   cdb_vld_pad_t                 cdb_vld_p;
   cdb_tag_pad_t                 cdb_tag_p;

   always_comb begin
      cdb_vld_p = '0;
      cdb_tag_p = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         cdb_vld_p[k]            = cdb_valid[k];
         cdb_tag_p[k][TAG_W-1:0] = cdb_tag[k*TAG_W +: TAG_W];
      end
   end

   always_comb begin
      tag_pad_t t;
      hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         t = '0;
         t[TAG_W-1:0] = live[i][TAG_W-1:0];
         hit[i] = live[i][TAG_W] & cdb_match(cdb_vld_p, cdb_tag_p, t);
      end
      // A producer whose result is broadcasting right now must not be recorded as pending.
      t = '0;
      t[TAG_W-1:0] = dispatch_tag;
      disp_kill = cdb_match(cdb_vld_p, cdb_tag_p, t);
   end

   assign disp_we = dispatch_wen & ~disp_kill & ~ckpt_restore & (dispatch_addr != '0);

   always_comb begin
      live_next = live;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (ckpt_restore)
            live_next[i] = restore_data[i];
         else if (disp_we && dispatch_addr == ADDR_W'(i))
            live_next[i] = {dispatch_valid, dispatch_tag};
         else if (hit[i])
            live_next[i][TAG_W] = 1'b0;
      end
      live_next[0] = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) live <= '0;
      else      live <= live_next;
   end

   reg_status_table_ckpt_bank #(
      .NUM_REGS (NUM_REGS),
      .TAG_W    (TAG_W),
      .NUM_CDB  (NUM_CDB),
      .NUM_CKPT (NUM_CKPT),
      .CKPT_W   (CKPT_W)
   ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .save_en      (ckpt_save & ~ckpt_restore),
      .save_id      (ckpt_save_id),
      .save_data    (live_next),
      .restore_id   (ckpt_restore_id),
      .restore_data (restore_data)
   );

   // Reads bypass this cycle's CDB clears but never this cycle's dispatch write.
   assign rs_ent           = live[dispatch_rsaddr];
   assign rt_ent           = live[dispatch_rtaddr];
   assign dispatch_rstag   = rs_ent[TAG_W-1:0];
   assign dispatch_rsvalid = rs_ent[TAG_W] & ~hit[dispatch_rsaddr];
   assign dispatch_rttag   = rt_ent[TAG_W-1:0];
   assign dispatch_rtvalid = rt_ent[TAG_W] & ~hit[dispatch_rtaddr];

   assign regfile_wen_onehot = {hit[NUM_REGS-1:1], 1'b0};

endmodule

// File: tb/tb_reg_status_table_ckpt.sv
// Directed scoreboard bench for reg_status_table_ckpt: driver queues expected reads/enables,
// monitor compares them on the falling edge.
module tb_reg_status_table_ckpt;

   localparam int NR = 32, TW = 6, NC = 2, NK = 4, AW = 5, KW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b0;
   logic           dispatch_wen = 0, dispatch_valid = 0, ckpt_save = 0, ckpt_restore = 0;
   logic [AW-1:0]  dispatch_addr = 0, dispatch_rsaddr = 0, dispatch_rtaddr = 0;
   logic [TW-1:0]  dispatch_tag = 0;
   logic [NC-1:0]  cdb_valid = 0;
   logic [NC*TW-1:0] cdb_tag = 0;
   logic [KW-1:0]  ckpt_save_id = 0, ckpt_restore_id = 0;
   logic [TW-1:0]  dispatch_rstag, dispatch_rttag;
   logic           dispatch_rsvalid, dispatch_rtvalid;
   logic [NR-1:0]  regfile_wen_onehot;

   reg_status_table_ckpt #(.NUM_REGS(NR), .TAG_W(TW), .NUM_CDB(NC), .NUM_CKPT(NK)) dut (
      .clk(clk), .rst(rst),
      .dispatch_wen(dispatch_wen), .dispatch_addr(dispatch_addr), .dispatch_tag(dispatch_tag),
      .dispatch_valid(dispatch_valid), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .dispatch_rsaddr(dispatch_rsaddr), .dispatch_rstag(dispatch_rstag),
      .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtaddr(dispatch_rtaddr),
      .dispatch_rttag(dispatch_rttag), .dispatch_rtvalid(dispatch_rtvalid),
      .regfile_wen_onehot(regfile_wen_onehot), .ckpt_save(ckpt_save),
      .ckpt_save_id(ckpt_save_id), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
   );

   typedef struct {
      logic rn; logic wen; logic [AW-1:0] addr; logic [TW-1:0] tag; logic dv;
      logic [NC-1:0] cv; logic [TW-1:0] ct0, ct1; logic [AW-1:0] rs, rt;
      logic sv; logic [KW-1:0] sid; logic rv; logic [KW-1:0] rid;
   } stim_t;

   typedef struct {
      string name; logic rsv; logic [TW-1:0] rstag; logic rtv; logic [TW-1:0] rttag; logic [NR-1:0] wen;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic chk = 1'b0;
   int   n_vec = 0, n_bad = 0;

   function automatic stim_t idle(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
      stim_t s;
      s = '{rn: 1'b1, wen: 1'b0, addr: '0, tag: '0, dv: 1'b0, cv: '0, ct0: '0, ct1: '0,
            rs: rs, rt: rt, sv: 1'b0, sid: '0, rv: 1'b0, rid: '0};
      return s;
   endfunction

   function automatic exp_t ex(input string n, input logic rsv, input logic [TW-1:0] rstag,
                               input logic rtv, input logic [TW-1:0] rttag, input logic [NR-1:0] wen);
      exp_t e;
      e.name = n; e.rsv = rsv; e.rstag = rstag; e.rtv = rtv; e.rttag = rttag; e.wen = wen;
      return e;
   endfunction

   task automatic cyc(input stim_t s, input bit do_chk, input exp_t e);
      @(posedge clk);
      #1;
      rst = s.rn; dispatch_wen = s.wen; dispatch_addr = s.addr; dispatch_tag = s.tag;
      dispatch_valid = s.dv; cdb_valid = s.cv; cdb_tag = {s.ct1, s.ct0};
      dispatch_rsaddr = s.rs; dispatch_rtaddr = s.rt;
      ckpt_save = s.sv; ckpt_save_id = s.sid; ckpt_restore = s.rv; ckpt_restore_id = s.rid;
      if (do_chk) sb.push_back(e);
      chk = do_chk;
   endtask

   task automatic go(input stim_t s, input exp_t e);
      cyc(s, 1'b1, e);
   endtask

   task automatic nochk(input stim_t s);
      cyc(s, 1'b0, ex("", 0, 0, 0, 0, 0));
   endtask

   always @(negedge clk) begin
      if (chk) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: monitor saw a check strobe with no expected entry");
         end else begin
            mon_e = sb.pop_front();
            if ({dispatch_rsvalid, dispatch_rstag, dispatch_rtvalid, dispatch_rttag, regfile_wen_onehot} !==
                {mon_e.rsv, mon_e.rstag, mon_e.rtv, mon_e.rttag, mon_e.wen}) begin
               n_bad++;
               $display("FAIL %s: got rs={%b,%h} rt={%b,%h} wen=%h expected rs={%b,%h} rt={%b,%h} wen=%h",
                        mon_e.name, dispatch_rsvalid, dispatch_rstag, dispatch_rtvalid, dispatch_rttag,
                        regfile_wen_onehot, mon_e.rsv, mon_e.rstag, mon_e.rtv, mon_e.rttag, mon_e.wen);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      // Reset held: writes and broadcasts have no effect, everything reads 0.
      s = idle(5, 7); s.rn = 0; s.wen = 1; s.addr = 5; s.tag = 6'h12; s.dv = 1; s.cv = 2'b01;
      go(s, ex("reset_a", 0, 0, 0, 0, 0));
      s = idle(0, 31); s.rn = 0; s.cv = 2'b11;
      go(s, ex("reset_b", 0, 0, 0, 0, 0));
      // Write r5 = 0x12; same-cycle read sees the old mapping.
      s = idle(5, 0); s.wen = 1; s.addr = 5; s.tag = 6'h12; s.dv = 1;
      go(s, ex("no_fwd", 0, 0, 0, 0, 0));
      s = idle(5, 0); s.wen = 1; s.addr = 0; s.tag = 6'h33; s.dv = 1;
      go(s, ex("r5_set", 1, 6'h12, 0, 0, 0));
      go(idle(5, 0), ex("r0_hard", 1, 6'h12, 0, 0, 0));
      // CDB0 broadcasts 0x12: bypassed read and regfile enable for r5.
      s = idle(5, 0); s.cv = 2'b01; s.ct0 = 6'h12;
      go(s, ex("cdb_bypass", 0, 6'h12, 0, 0, 32'h0000_0020));
      go(idle(5, 0), ex("r5_clr", 0, 6'h12, 0, 0, 0));
      // r7 = 0x15, then a dispatch of tag 0x20 killed by CDB1 carrying 0x20.
      s = idle(7, 0); s.wen = 1; s.addr = 7; s.tag = 6'h15; s.dv = 1;
      go(s, ex("r7_old", 0, 0, 0, 0, 0));
      s = idle(7, 0); s.wen = 1; s.addr = 7; s.tag = 6'h20; s.dv = 1; s.cv = 2'b10; s.ct1 = 6'h20;
      go(s, ex("sup_same", 1, 6'h15, 0, 0, 0));
      go(idle(7, 0), ex("sup_keep", 1, 6'h15, 0, 0, 0));
      // Checkpoint r3 = 0x04 in slot 2, overwrite, retire 0x04, restore.
      s = idle(3, 0); s.wen = 1; s.addr = 3; s.tag = 6'h04; s.dv = 1;
      nochk(s);
      s = idle(3, 0); s.sv = 1; s.sid = 2;
      go(s, ex("r3_saved", 1, 6'h04, 0, 0, 0));
      s = idle(3, 0); s.wen = 1; s.addr = 3; s.tag = 6'h09; s.dv = 1;
      go(s, ex("r3_pre", 1, 6'h04, 0, 0, 0));
      s = idle(3, 0); s.cv = 2'b01; s.ct0 = 6'h04;
      go(s, ex("r3_new", 1, 6'h09, 0, 0, 0));
      s = idle(3, 7); s.rv = 1; s.rid = 2;
      go(s, ex("pre_restore", 1, 6'h09, 1, 6'h15, 0));
      go(idle(3, 7), ex("restore_clr", 0, 6'h04, 1, 6'h15, 0));
      // Slot 1 holds r8 = 0x2a, slot 0 holds r8 = 0x2b; restore+dispatch+save in one cycle.
      s = idle(8, 7); s.wen = 1; s.addr = 8; s.tag = 6'h2a; s.dv = 1;
      nochk(s);
      s = idle(8, 7); s.sv = 1; s.sid = 1;
      nochk(s);
      s = idle(8, 7); s.wen = 1; s.addr = 8; s.tag = 6'h2b; s.dv = 1;
      nochk(s);
      s = idle(8, 7); s.sv = 1; s.sid = 0;
      nochk(s);
      s = idle(8, 7); s.wen = 1; s.addr = 8; s.tag = 6'h2c; s.dv = 1;
      nochk(s);
      s = idle(8, 7); s.rv = 1; s.rid = 1; s.wen = 1; s.addr = 8; s.tag = 6'h11; s.dv = 1;
      s.sv = 1; s.sid = 0;
      go(s, ex("combo_pre", 1, 6'h2c, 1, 6'h15, 0));
      go(idle(8, 7), ex("restore_prio", 1, 6'h2a, 1, 6'h15, 0));
      s = idle(8, 7); s.rv = 1; s.rid = 0;
      go(s, ex("slot0_pre", 1, 6'h2a, 1, 6'h15, 0));
      go(idle(8, 7), ex("slot0_keep", 1, 6'h2b, 1, 6'h15, 0));
      // Both CDBs carry the same tag: single clear.
      s = idle(8, 7); s.cv = 2'b11; s.ct0 = 6'h2b; s.ct1 = 6'h2b;
      go(s, ex("dual_cdb", 0, 6'h2b, 1, 6'h15, 32'h0000_0100));
      go(idle(8, 7), ex("dual_after", 0, 6'h2b, 1, 6'h15, 0));
      // Clear and overwrite of r7 in one cycle: enable still fires, dispatch wins.
      s = idle(7, 8); s.wen = 1; s.addr = 7; s.tag = 6'h30; s.dv = 1; s.cv = 2'b10; s.ct1 = 6'h15;
      go(s, ex("wen_overwr", 0, 6'h15, 0, 6'h2b, 32'h0000_0080));
      go(idle(7, 8), ex("disp_over_clr", 1, 6'h30, 0, 6'h2b, 0));
      // Mid-operation reset clears live table and slots.
      s = idle(7, 8); s.rn = 0;
      go(s, ex("midrst", 0, 0, 0, 0, 0));
      go(idle(7, 8), ex("midrst_rel", 0, 0, 0, 0, 0));
      s = idle(8, 7); s.rv = 1; s.rid = 0;
      nochk(s);
      go(idle(8, 7), ex("slot_rst", 0, 0, 0, 0, 0));

      @(posedge clk);
      #1;
      chk = 1'b0;
      @(posedge clk);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d expected entries never compared, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
